mips_multicycle_control: RTL and testbench

- Main control FSM for the multicycle MIPS datapath.
- Sequences instruction fetch, decode, execute, memory access and writeback.
- Drives the 2-bit ALU-op code consumed by the ALU control decoder: 00 add, 01 subtract, 10 use funct.
- Adds a memory-ready handshake, illegal-opcode detection and a retired-instruction counter.

---
 rtl/mips_multicycle_control.sv | 173 +++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath, with memory-ready handshake,
// illegal-opcode detection and retired-instruction counter. Optional macro: SINGLE_STEP_EN.
module mips_multicycle_control #(
    parameter int unsigned COUNT_W      = 16,
    parameter int unsigned ILLEGAL_HALT = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [5:0]         opcode,
`ifdef SINGLE_STEP_EN
    input  logic               step,
`endif
    input  logic               mem_ready,
    output logic               mem_read,
    output logic               mem_write,
    output logic               iord,
    output logic               ir_write,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic [1:0]         pc_source,
    output logic [1:0]         alu_op,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic [3:0]         state,
    output logic               illegal_op,
    output logic [COUNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXEC    = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        JUMP    = 4'd9,
        ILLEGAL = 4'd10,
        HALT    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t state_q;
    logic   adv;

`ifdef SINGLE_STEP_EN
    assign adv = step;
`else
    assign adv = 1'b1;
`endif

    assign state = state_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= FETCH;
            instr_count <= '0;
            illegal_op  <= 1'b0;
        end else if (adv) begin
            case (state_q)
                FETCH:  if (mem_ready) state_q <= DECODE;
                DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: state_q <= MEMADR;
                        OP_RTYPE:     state_q <= EXEC;
                        OP_BEQ:       state_q <= BRANCH;
                        OP_J:         state_q <= JUMP;
                        default: begin
                            state_q    <= ILLEGAL;
                            illegal_op <= 1'b1;
                        end
                    endcase
                end
                MEMADR: state_q <= (opcode == OP_SW) ? MEMWR : MEMRD;
                MEMRD:  if (mem_ready) state_q <= MEMWB;
                MEMWR: begin
                    if (mem_ready) begin
                        state_q     <= FETCH;
                        instr_count <= instr_count + COUNT_W'(1);
                    end
                end
                EXEC:   state_q <= ALUWB;
                MEMWB, ALUWB, BRANCH, JUMP: begin
                    state_q     <= FETCH;
                    instr_count <= instr_count + COUNT_W'(1);
                end
                ILLEGAL: state_q <= (ILLEGAL_HALT != 0) ? HALT : FETCH;
                HALT:    state_q <= HALT;
                default: state_q <= FETCH;
            endcase
        end
    end

    // Moore decode; request/write strobes are then masked by reset and by a held step.
    always_comb begin
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        alu_op        = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            DECODE: alu_src_b = 2'b11;
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            default: ;
        endcase
        if (!(reset_n && adv)) begin
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            reg_write     = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed, table-driven bench for mips_multicycle_control; a second instance covers ILLEGAL_HALT=0.
module tb_mips_multicycle_control;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] opcode = '0;
    logic       mem_ready = 1'b0;
    logic       step = 1'b1;

    logic       mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond;
    logic [1:0] pc_source, alu_op, alu_src_b;
    logic       alu_src_a, reg_write, reg_dst, mem_to_reg, illegal_op;
    logic [3:0] state;
    logic [3:0] instr_count;

    logic        b_mem_read, b_mem_write, b_iord, b_ir_write, b_pc_write, b_pc_write_cond;
    logic [1:0]  b_pc_source, b_alu_op, b_alu_src_b;
    logic        b_alu_src_a, b_reg_write, b_reg_dst, b_mem_to_reg, b_illegal_op;
    logic [3:0]  b_state;
    logic [15:0] b_instr_count;

    always #5 clk = ~clk;

    mips_multicycle_control #(.COUNT_W(4), .ILLEGAL_HALT(1)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode),
`ifdef SINGLE_STEP_EN
        .step(step),
`endif
        .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
        .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .pc_source(pc_source), .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .state(state),
        .illegal_op(illegal_op), .instr_count(instr_count)
    );

    mips_multicycle_control #(.COUNT_W(16), .ILLEGAL_HALT(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .opcode(opcode),
`ifdef SINGLE_STEP_EN
        .step(step),
`endif
        .mem_ready(mem_ready), .mem_read(b_mem_read), .mem_write(b_mem_write), .iord(b_iord),
        .ir_write(b_ir_write), .pc_write(b_pc_write), .pc_write_cond(b_pc_write_cond),
        .pc_source(b_pc_source), .alu_op(b_alu_op), .alu_src_a(b_alu_src_a),
        .alu_src_b(b_alu_src_b), .reg_write(b_reg_write), .reg_dst(b_reg_dst),
        .mem_to_reg(b_mem_to_reg), .state(b_state), .illegal_op(b_illegal_op),
        .instr_count(b_instr_count)
    );

    // {mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond, pc_source, alu_op,
    //  alu_src_a, alu_src_b, reg_write, reg_dst, mem_to_reg}
    logic [15:0] ctl;
    assign ctl = {mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond, pc_source,
                  alu_op, alu_src_a, alu_src_b, reg_write, reg_dst, mem_to_reg};

    localparam logic [15:0] C_FW   = 16'b1_0_0_0_0_0_00_00_0_01_0_0_0;
    localparam logic [15:0] C_FR   = 16'b1_0_0_1_1_0_00_00_0_01_0_0_0;
    localparam logic [15:0] C_DEC  = 16'b0_0_0_0_0_0_00_00_0_11_0_0_0;
    localparam logic [15:0] C_MADR = 16'b0_0_0_0_0_0_00_00_1_10_0_0_0;
    localparam logic [15:0] C_MRD  = 16'b1_0_1_0_0_0_00_00_0_00_0_0_0;
    localparam logic [15:0] C_MWB  = 16'b0_0_0_0_0_0_00_00_0_00_1_0_1;
    localparam logic [15:0] C_MWR  = 16'b0_1_1_0_0_0_00_00_0_00_0_0_0;
    localparam logic [15:0] C_EXE  = 16'b0_0_0_0_0_0_00_10_1_00_0_0_0;
    localparam logic [15:0] C_AWB  = 16'b0_0_0_0_0_0_00_00_0_00_1_1_0;
    localparam logic [15:0] C_BRA  = 16'b0_0_0_0_0_1_01_01_1_00_0_0_0;
    localparam logic [15:0] C_JMP  = 16'b0_0_0_0_1_0_10_00_0_00_0_0_0;

    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010, BAD = 6'b111111;

    typedef struct {
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [15:0] ctl;
        logic [3:0]  cnt;
    } vec_t;

    vec_t tv[$];
    int   total = 0;
    int   passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic add(input logic [5:0] op, input logic rdy, input logic [3:0] st,
                       input logic [15:0] c, input logic [3:0] cnt);
        vec_t v;
        v.op = op; v.rdy = rdy; v.st = st; v.ctl = c; v.cnt = cnt;
        tv.push_back(v);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_j(input logic [3:0] exp_cnt);
        opcode = J; mem_ready = 1'b1;
        tick; tick;
        @(negedge clk);
        chk("j_state", 32'(state), 32'd9);
        tick;
        @(negedge clk);
        chk("j_count", 32'(instr_count), 32'(exp_cnt));
    endtask

    initial begin
        // R-type, mem_ready low outside FETCH must not stall
        add(R, 1, 0, C_FR, 0);   add(R, 0, 1, C_DEC, 0);
        add(R, 0, 6, C_EXE, 0);  add(R, 0, 7, C_AWB, 0);
        // lw: 3 FETCH wait cycles, 2 MEMRD wait cycles
        add(LW, 0, 0, C_FW, 1);  add(LW, 0, 0, C_FW, 1);  add(LW, 0, 0, C_FW, 1);
        add(LW, 1, 0, C_FR, 1);  add(LW, 0, 1, C_DEC, 1); add(LW, 1, 2, C_MADR, 1);
        add(LW, 0, 3, C_MRD, 1); add(LW, 0, 3, C_MRD, 1); add(LW, 1, 3, C_MRD, 1);
        add(LW, 0, 4, C_MWB, 1);
        // sw with one MEMWR wait
        add(SW, 1, 0, C_FR, 2);  add(SW, 1, 1, C_DEC, 2); add(SW, 0, 2, C_MADR, 2);
        add(SW, 0, 5, C_MWR, 2); add(SW, 1, 5, C_MWR, 2);
        add(BEQ, 1, 0, C_FR, 3); add(BEQ, 1, 1, C_DEC, 3); add(BEQ, 1, 8, C_BRA, 3);
        add(J, 1, 0, C_FR, 4);   add(J, 1, 1, C_DEC, 4);  add(J, 0, 9, C_JMP, 4);
        add(BAD, 1, 0, C_FR, 5);

        step = 1'b1; reset_n = 1'b0; mem_ready = 1'b1;
        tick;
        @(negedge clk);
        chk("rst_mem_read_gated", 32'(mem_read), 32'd0);
        chk("rst_ir_write_gated", 32'(ir_write), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_count", 32'(instr_count), 32'd0);
        chk("rst_illegal", 32'(illegal_op), 32'd0);
        tick;
        reset_n = 1'b1;

        foreach (tv[i]) begin
            opcode = tv[i].op; mem_ready = tv[i].rdy;
            @(negedge clk);
            chk($sformatf("tv%0d_state", i), 32'(state), 32'(tv[i].st));
            chk($sformatf("tv%0d_ctl", i), 32'(ctl), 32'(tv[i].ctl));
            chk($sformatf("tv%0d_count", i), 32'(instr_count), 32'(tv[i].cnt));
            chk($sformatf("tv%0d_illegal", i), 32'(illegal_op), 32'd0);
            tick;
        end

        // illegal opcode: halting instance parks, non-halting returns to FETCH without retiring
        opcode = BAD; mem_ready = 1'b0;
        @(negedge clk);
        chk("ill_decode", 32'(state), 32'd1);
        tick;
        @(negedge clk);
        chk("ill_state", 32'(state), 32'd10);
        chk("ill_flag", 32'(illegal_op), 32'd1);
        chk("ill_b_state", 32'(b_state), 32'd10);
        tick;
        @(negedge clk);
        chk("ill_b_fetch", 32'(b_state), 32'd0);
        chk("ill_b_flag", 32'(b_illegal_op), 32'd1);
        chk("ill_b_count", 32'(b_instr_count), 32'd5);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("halt_state", 32'(state), 32'd11);
            chk("halt_ctl", 32'(ctl), 32'd0);
            chk("halt_count", 32'(instr_count), 32'd5);
            tick;
        end
        chk("halt_flag", 32'(illegal_op), 32'd1);
        chk("ill_b_hold", 32'(b_state), 32'd0);
        reset_n = 1'b0;
        tick;
        reset_n = 1'b1;
        @(negedge clk);
        chk("unhalt_state", 32'(state), 32'd0);
        chk("unhalt_flag", 32'(illegal_op), 32'd0);
        chk("unhalt_count", 32'(instr_count), 32'd0);

        // counter wrap on the 4-bit instance; 16-bit instance keeps counting
        for (int k = 1; k <= 15; k++) do_j(4'(k));
        do_j(4'd0);
        chk("wrap_b_count", 32'(b_instr_count), 32'd16);

        // reset during MEMWR: no retire, mem_write dropped that cycle
        opcode = SW; mem_ready = 1'b1;
        tick; tick;
        mem_ready = 1'b0;
        tick;
        @(negedge clk);
        chk("mwr_state", 32'(state), 32'd5);
        chk("mwr_write", 32'(mem_write), 32'd1);
        tick;
        reset_n = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        chk("mwr_rst_write", 32'(mem_write), 32'd0);
        tick;
        reset_n = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        chk("mwr_rst_state", 32'(state), 32'd0);
        chk("mwr_rst_count", 32'(instr_count), 32'd0);
        chk("mwr_rst_b_count", 32'(b_instr_count), 32'd0);

`ifdef SINGLE_STEP_EN
        // one state per step pulse; strobes only in the stepped cycle
        opcode = R; mem_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step = ((k % 4) == 3);
            @(negedge clk);
            chk("ss_state", 32'(state), (k < 4) ? 32'd0 : (k < 8) ? 32'd1 :
                                        (k < 12) ? 32'd6 : (k < 16) ? 32'd7 : 32'd0);
            chk("ss_reg_write", 32'(reg_write), (k == 15) ? 32'd1 : 32'd0);
            chk("ss_mem_read", 32'(mem_read), (k == 3 || k == 19) ? 32'd1 : 32'd0);
            chk("ss_count", 32'(instr_count), (k < 16) ? 32'd0 : 32'd1);
            tick;
        end
        step = 1'b1;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
